mips_commit_checker: RTL
========================

// Module: mips_commit_checker
// PURPOSE
// - Parametrised, reusable replacement for hand-written per-PC checks in singleMIPS benches.
// - Observes the core's retire stream (pc, aluout, readData, writeData) and matches each retire against a PC-keyed expectation table.
// - Counts mismatches and checks branch/jump targets via expected next-PC.
// - Flags forbidden PCs, ends the run on a cycle budget, and reports pass/fail.
// PARAMETERS
// - DATA_W      32  width of pc/aluout/readData/writeData
// - ENTRIES     16  expectation table depth; IDX_W = $clog2(ENTRIES)
// - ERR_W       8   error counter width (saturating)
// - MAX_CYCLES  20  RUN-state cycle budget before DONE
// - HIST_DEPTH  8   retired-PC history depth (only with CHK_HISTORY_EN); power of 2
// PORTS
// - clk          in   1       rising-edge clock
// - reset        in   1       synchronous, active-high
// - start        in   1       IDLE/DONE -> RUN pulse
// - stop         in   1       RUN -> DONE pulse
// - exp_we       in   1       table write strobe, honoured only in IDLE
// - exp_idx      in   IDX_W   table slot
// - exp_mask     in   5       {forbid, npc, wd, rd, alu}; 0 invalidates slot
// - exp_pc       in   DATA_W  match key
// - exp_alu, exp_rd, exp_wd, exp_npc  in  DATA_W  expected values
// - ret_valid    in   1       a retire occurs this cycle
// - pc, aluout, readData, writeData   in  DATA_W  core outputs
// - running      out  1       state==RUN
// - done         out  1       state==DONE
// - pass         out  1       done && err_cnt==0
// - err_cnt      out  ERR_W   mismatch count
// - first_err_pc out  DATA_W  pc of first error
// - first_err_kind out 5      mask bit(s) that failed first
// - hist_idx     in   $clog2(HIST_DEPTH)  history read index (0 = newest)
// - hist_pc      out  DATA_W  history read data
// BEHAVIOUR
// - Reset: state IDLE; all table slots invalid; all outputs 0; npc_pend=0; cyc=0.
// - FSM IDLE --start--> RUN; RUN --stop | cyc==MAX_CYCLES-1--> DONE; DONE --start--> RUN.
// - Entering RUN clears err_cnt, first_err_*, cyc, npc_pend and history; the table is kept.
// - Table writes: exp_we in IDLE writes slot exp_idx; exp_we in RUN/DONE is ignored.
// - A write in the same cycle as start is accepted.
// - Checks are active only in RUN with ret_valid; a retire in the start cycle is not checked.
// - Lookup: lowest-index valid slot with exp_pc==pc; no hit means no value check.
// - On hit, compare alu/rd/wd fields whose mask bits are set; forbid set = error.
// - On hit with npc set, latch npc_pend=1 and npc_exp; the next ret_valid compares pc to npc_exp, then clears npc_pend.
// - Error accounting: each retire with >=1 failure adds exactly 1 (npc failure counted on the retire it is detected).
// - err_cnt saturates at 2^ERR_W-1.
// - first_err_* captured once per run, on the first increment.
// - Latency: err_cnt/first_err_* visible 1 cycle after the offending retire; done 1 cycle after the terminating condition.
// - stop and a failing retire in the same cycle: the error is counted, then DONE.
// - Reset mid-RUN: immediate return to the reset state; the table is lost.
// CONFIGURATION
// - CHK_HISTORY_EN defined: circular buffer of the last HIST_DEPTH checked retire PCs.
//   Write pointer wraps; hist_pc = entry hist_idx back from newest, read combinationally.
// - CHK_HISTORY_EN undefined: buffer not built; hist_pc tied to 0; hist_idx ignored.
// STRUCTURE
// - Package mips_chk_pkg: state enum {IDLE, RUN, DONE}, mask bit indices (ALU=0, RD=1, WD=2, NPC=3, FORBID=4), entry typedef.
// - One sub-module, mips_chk_cam: table storage plus priority PC match (hit, hit_idx).
// - FSM, comparison, counters and history stay in the top.
// TESTING
// - Load slot0 {pc=0x0c, mask=alu|wd, 4, -, 5}; start; retire pc=0x0c alu=4 wd=5 -> err_cnt stays 0.
// - Same slot; retire pc=0x0c alu=4 wd=6 -> err_cnt=1, first_err_pc=0x0c, first_err_kind=00100.
// - Slot {pc=0x24, npc=0x28}; retires 0x24 then 0x2c -> err_cnt=1 on 2nd retire; 0x24 then 0x28 -> 0.
// - Slot {pc=0x2c, forbid}; retire 0x2c -> err_cnt=1; 300 failing retires, ERR_W=8 -> err_cnt=255.
// - start with no retires, MAX_CYCLES=20 -> done high 20 cycles after start, pass=1.
// - Reset asserted mid-RUN -> next cycle running=0, err_cnt=0, table empty.
// - exp_we during RUN -> table unchanged.

Source files
------------

// File: rtl/mips_chk_pkg.sv
// Shared types for the MIPS commit checker: FSM states and expectation-mask bit positions.
package mips_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam int MASK_W      = 5;
  localparam int MASK_ALU    = 0;
  localparam int MASK_RD     = 1;
  localparam int MASK_WD     = 2;
  localparam int MASK_NPC    = 3;
  localparam int MASK_FORBID = 4;

  // A table entry's mask doubles as its valid flag: an all-zero mask means an empty slot.
  typedef logic [MASK_W-1:0] chk_mask_t;

endpackage

// File: rtl/mips_chk_cam.sv
// Expectation table for the commit checker: slot storage, lowest-index PC match and a read port.
module mips_chk_cam
  import mips_chk_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wrIdx,
  input  logic [MASK_W-1:0] i_wrMask,
  input  logic [DATA_W-1:0] i_wrPc,
  input  logic [DATA_W-1:0] i_wrAlu,
  input  logic [DATA_W-1:0] i_wrRd,
  input  logic [DATA_W-1:0] i_wrWd,
  input  logic [DATA_W-1:0] i_wrNpc,
  input  logic [DATA_W-1:0] i_lookupPc,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_hitIdx,
  input  logic [IDX_W-1:0]  i_rdIdx,
  output logic [MASK_W-1:0] o_rdMask,
  output logic [DATA_W-1:0] o_rdAlu,
  output logic [DATA_W-1:0] o_rdRd,
  output logic [DATA_W-1:0] o_rdWd,
  output logic [DATA_W-1:0] o_rdNpc
);

  chk_mask_t         r_mask [ENTRIES];
  logic [DATA_W-1:0] r_pc   [ENTRIES];
  logic [DATA_W-1:0] r_alu  [ENTRIES];
  logic [DATA_W-1:0] r_rd   [ENTRIES];
  logic [DATA_W-1:0] r_wd   [ENTRIES];
  logic [DATA_W-1:0] r_npc  [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mask[i] <= '0;
        r_pc[i]   <= '0;
        r_alu[i]  <= '0;
        r_rd[i]   <= '0;
        r_wd[i]   <= '0;
        r_npc[i]  <= '0;
      end
    end else if (i_we) begin
      r_mask[i_wrIdx] <= i_wrMask;
      r_pc[i_wrIdx]   <= i_wrPc;
      r_alu[i_wrIdx]  <= i_wrAlu;
      r_rd[i_wrIdx]   <= i_wrRd;
      r_wd[i_wrIdx]   <= i_wrWd;
      r_npc[i_wrIdx]  <= i_wrNpc;
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    o_hit    = 1'b0;
    o_hitIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if ((r_mask[i] != '0) && (r_pc[i] == i_lookupPc)) begin
        o_hit    = 1'b1;
        o_hitIdx = IDX_W'(i);
      end
    end
  end

  assign o_rdMask = r_mask[i_rdIdx];
  assign o_rdAlu  = r_alu[i_rdIdx];
  assign o_rdRd   = r_rd[i_rdIdx];
  assign o_rdWd   = r_wd[i_rdIdx];
  assign o_rdNpc  = r_npc[i_rdIdx];

endmodule

// File: rtl/mips_commit_checker.sv
// Retire-stream checker for singleMIPS benches: PC-keyed expectations, next-PC checks, cycle budget.
// Optional retired-PC history buffer is built when CHK_HISTORY_EN is defined.
module mips_commit_checker
  import mips_chk_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ENTRIES    = 16,
  parameter int ERR_W      = 8,
  parameter int MAX_CYCLES = 20,
  parameter int HIST_DEPTH = 8,
  parameter int IDX_W      = $clog2(ENTRIES),
  parameter int HIST_W     = $clog2(HIST_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [4:0]        exp_mask,
  input  logic [DATA_W-1:0] exp_pc,
  input  logic [DATA_W-1:0] exp_alu,
  input  logic [DATA_W-1:0] exp_rd,
  input  logic [DATA_W-1:0] exp_wd,
  input  logic [DATA_W-1:0] exp_npc,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] writeData,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [DATA_W-1:0] first_err_pc,
  output logic [4:0]        first_err_kind,
  input  logic [HIST_W-1:0] hist_idx,
  output logic [DATA_W-1:0] hist_pc
);

  localparam int CYC_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  chk_state_t        r_state, w_nextState;
  logic [CYC_W-1:0]  r_cyc;
  logic [ERR_W-1:0]  r_errCnt;
  logic [DATA_W-1:0] r_firstErrPc;
  chk_mask_t         r_firstErrKind;
  logic              r_npcPend;
  logic [DATA_W-1:0] r_npcExp;

  logic              w_enterRun, w_check, w_fail;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hitIdx;
  chk_mask_t         w_hitMask, w_kind;
  logic [DATA_W-1:0] w_hitAlu, w_hitRd, w_hitWd, w_hitNpc;

  mips_chk_cam #(.DATA_W(DATA_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cam (
    .clk        (clk),
    .reset      (reset),
    .i_we       (exp_we && (r_state == IDLE)),
    .i_wrIdx    (exp_idx),
    .i_wrMask   (exp_mask),
    .i_wrPc     (exp_pc),
    .i_wrAlu    (exp_alu),
    .i_wrRd     (exp_rd),
    .i_wrWd     (exp_wd),
    .i_wrNpc    (exp_npc),
    .i_lookupPc (pc),
    .o_hit      (w_hit),
    .o_hitIdx   (w_hitIdx),
    .i_rdIdx    (w_hitIdx),
    .o_rdMask   (w_hitMask),
    .o_rdAlu    (w_hitAlu),
    .o_rdRd     (w_hitRd),
    .o_rdWd     (w_hitWd),
    .o_rdNpc    (w_hitNpc)
  );

  assign w_enterRun = start && (r_state != RUN);
  assign w_check    = (r_state == RUN) && ret_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (stop || (r_cyc == CYC_LAST)) w_nextState = DONE;
      DONE:    if (start) w_nextState = RUN;
      default: w_nextState = IDLE;
    endcase
  end

  // A pending next-PC check is judged on whatever retires next, hit or not.
  always_comb begin
    w_kind = '0;
    if (w_check) begin
      if (w_hit) begin
        w_kind[MASK_ALU]    = w_hitMask[MASK_ALU] && (aluout != w_hitAlu);
        w_kind[MASK_RD]     = w_hitMask[MASK_RD] && (readData != w_hitRd);
        w_kind[MASK_WD]     = w_hitMask[MASK_WD] && (writeData != w_hitWd);
        w_kind[MASK_FORBID] = w_hitMask[MASK_FORBID];
      end
      w_kind[MASK_NPC] = r_npcPend && (pc != r_npcExp);
    end
  end

  assign w_fail = |w_kind;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc          <= '0;
      r_errCnt       <= '0;
      r_firstErrPc   <= '0;
      r_firstErrKind <= '0;
      r_npcPend      <= 1'b0;
      r_npcExp       <= '0;
    end else if (w_enterRun) begin
      r_cyc          <= '0;
      r_errCnt       <= '0;
      r_firstErrPc   <= '0;
      r_firstErrKind <= '0;
      r_npcPend      <= 1'b0;
    end else if (r_state == RUN) begin
      if (r_cyc != CYC_LAST) r_cyc <= r_cyc + 1'b1;
      if (w_check) begin
        if (w_fail && (r_errCnt != ERR_MAX)) r_errCnt <= r_errCnt + 1'b1;
        if (w_fail && (r_errCnt == '0)) begin
          r_firstErrPc   <= pc;
          r_firstErrKind <= w_kind;
        end
        r_npcPend <= w_hit && w_hitMask[MASK_NPC];
        if (w_hit && w_hitMask[MASK_NPC]) r_npcExp <= w_hitNpc;
      end
    end
  end

  assign running        = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign pass           = done && (r_errCnt == '0);
  assign err_cnt        = r_errCnt;
  assign first_err_pc   = r_firstErrPc;
  assign first_err_kind = r_firstErrKind;

`ifdef CHK_HISTORY_EN
  logic [DATA_W-1:0] r_hist [HIST_DEPTH];
  logic [HIST_W-1:0] r_histWr;
  logic [HIST_W-1:0] w_histRd;

  always_ff @(posedge clk) begin
    if (reset || w_enterRun) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      r_histWr <= '0;
    end else if (w_check) begin
      r_hist[r_histWr] <= pc;
      r_histWr         <= r_histWr + 1'b1;
    end
  end

  // Newest entry sits one behind the write pointer; hist_idx walks further back.
  assign w_histRd = r_histWr - HIST_W'(1) - hist_idx;
  assign hist_pc  = r_hist[w_histRd];
`else
  // Always zero; hist_idx is folded in only so the unused port stays consumed.
  assign hist_pc = {DATA_W{1'b0}} & {DATA_W{^hist_idx}};
`endif

endmodule
